alu_serial_div: RTL and testbench

Multi-cycle serial divider that responds to the EX-stage ALU request handshake (enable_i / operator_i / operands, ex_ready_i, ready_o) for the divide/remainder operators. It latches operands on a start request and iterates one quotient bit per cycle. It holds the result with ready_o high until the EX stage accepts it with ex_ready_i. It sits inside the ALU next to the single-cycle datapath; the ALU muxes its result_o/ready_o for div-class operators.

---
 rtl/alu_serial_div.sv | 172 +++++++++++++++++
 tb/tb_alu_serial_div.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/alu_serial_div.sv
// rtl/alu_serial_div.sv - multi-cycle restoring divider for ALU DIV/DIVU/REM/REMU
// Optional early termination on dividend magnitude: define ALU_DIV_EARLY_TERM_EN
module alu_serial_div #(
  parameter int WIDTH    = 32,
  parameter int OP_WIDTH = 7
) (
  input  logic                core_clk,
  input  logic                rst_n,
  input  logic                enable_i,
  input  logic [OP_WIDTH-1:0] operator_i,
  input  logic [WIDTH-1:0]    operand_a_i,
  input  logic [WIDTH-1:0]    operand_b_i,
  input  logic                ex_ready_i,
  output logic [WIDTH-1:0]    result_o,
  output logic                ready_o,
  output logic                busy_o
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [OP_WIDTH-1:0] ALU_DIVU = OP_WIDTH'(7'b0110000);
  localparam logic [OP_WIDTH-1:0] ALU_DIV  = OP_WIDTH'(7'b0110001);
  localparam logic [OP_WIDTH-1:0] ALU_REMU = OP_WIDTH'(7'b0110010);
  localparam logic [OP_WIDTH-1:0] ALU_REM  = OP_WIDTH'(7'b0110011);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             is_rem_q, is_rem_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;

  logic             is_div_op, op_signed, op_rem, start;
  logic             a_neg, b_neg, div_zero, overflow, a_zero;
  logic [WIDTH-1:0] abs_a, abs_b, quo_init;
  logic [CW-1:0]    iter_cnt;

  logic [WIDTH:0]   trial;
  logic             trial_ge;
  logic [WIDTH-1:0] rem_step, quo_step;

  assign is_div_op = (operator_i == ALU_DIVU) || (operator_i == ALU_DIV) ||
                     (operator_i == ALU_REMU) || (operator_i == ALU_REM);
  assign op_signed = (operator_i == ALU_DIV)  || (operator_i == ALU_REM);
  assign op_rem    = (operator_i == ALU_REMU) || (operator_i == ALU_REM);
  assign start     = enable_i && is_div_op;

  assign a_neg    = op_signed && operand_a_i[WIDTH-1];
  assign b_neg    = op_signed && operand_b_i[WIDTH-1];
  assign abs_a    = a_neg ? -operand_a_i : operand_a_i;
  assign abs_b    = b_neg ? -operand_b_i : operand_b_i;
  assign div_zero = (operand_b_i == '0);
  assign overflow = op_signed && (operand_a_i == {1'b1, {(WIDTH-1){1'b0}}}) &&
                    (operand_b_i == '1);

`ifdef ALU_DIV_EARLY_TERM_EN
  // Pre-align the dividend so its top set bit enters the remainder on the first step.
  logic [CW-1:0] msb_idx;
  always_comb begin
    msb_idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (abs_a[i]) msb_idx = CW'(i);
    end
  end
  assign iter_cnt = msb_idx + CW'(1);
  assign quo_init = abs_a << (CW'(WIDTH - 1) - msb_idx);
  assign a_zero   = (abs_a == '0);
`else
  assign iter_cnt = CW'(WIDTH);
  assign quo_init = abs_a;
  assign a_zero   = 1'b0;
`endif

  // The trial value can exceed WIDTH bits for large unsigned divisors.
  assign trial    = {rem_q, quo_q[WIDTH-1]};
  assign trial_ge = (trial >= {1'b0, div_q});
  assign rem_step = trial_ge ? (trial[WIDTH-1:0] - div_q) : trial[WIDTH-1:0];
  assign quo_step = {quo_q[WIDTH-2:0], trial_ge};

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    div_d     = div_q;
    cnt_d     = cnt_q;
    is_rem_d  = is_rem_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;
    ready_o   = 1'b1;
    busy_o    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          ready_o = 1'b0;
          if (div_zero) begin
            state_d  = S_DONE;
            result_d = op_rem ? operand_a_i : '1;
          end else if (overflow) begin
            state_d  = S_DONE;
            result_d = op_rem ? '0 : operand_a_i;
          end else if (a_zero) begin
            state_d  = S_DONE;
            result_d = '0;
          end else begin
            state_d   = S_BUSY;
            rem_d     = '0;
            quo_d     = quo_init;
            div_d     = abs_b;
            cnt_d     = iter_cnt;
            is_rem_d  = op_rem;
            neg_quo_d = a_neg ^ b_neg;
            neg_rem_d = a_neg;
          end
        end
      end
      S_BUSY: begin
        ready_o = 1'b0;
        busy_o  = 1'b1;
        rem_d   = rem_step;
        quo_d   = quo_step;
        cnt_d   = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = S_DONE;
          if (is_rem_q) result_d = neg_rem_q ? -rem_step : rem_step;
          else          result_d = neg_quo_q ? -quo_step : quo_step;
        end
      end
      S_DONE: begin
        if (ex_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge core_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      rem_q     <= '0;
      quo_q     <= '0;
      div_q     <= '0;
      cnt_q     <= '0;
      is_rem_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      div_q     <= div_d;
      cnt_q     <= cnt_d;
      is_rem_q  <= is_rem_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
    end
  end

  assign result_o = result_q;

endmodule

// File: tb/tb_alu_serial_div.sv
// tb/tb_alu_serial_div.sv - directed-vector bench for alu_serial_div
module tb_alu_serial_div;

  localparam logic [6:0] OP_DIVU = 7'b0110000;
  localparam logic [6:0] OP_DIV  = 7'b0110001;
  localparam logic [6:0] OP_REMU = 7'b0110010;
  localparam logic [6:0] OP_REM  = 7'b0110011;

  logic        core_clk = 1'b0;
  logic        rst_n;
  logic        enable_i;
  logic [6:0]  operator_i;
  logic [31:0] operand_a_i;
  logic [31:0] operand_b_i;
  logic        ex_ready_i;
  logic [31:0] result_o;
  logic        ready_o;
  logic        busy_o;

  int n_checks = 0;
  int n_errors = 0;

  alu_serial_div #(.WIDTH(32), .OP_WIDTH(7)) dut (
    .core_clk   (core_clk),
    .rst_n      (rst_n),
    .enable_i   (enable_i),
    .operator_i (operator_i),
    .operand_a_i(operand_a_i),
    .operand_b_i(operand_b_i),
    .ex_ready_i (ex_ready_i),
    .result_o   (result_o),
    .ready_o    (ready_o),
    .busy_o     (busy_o)
  );

  always #5 core_clk = ~core_clk;

  typedef struct {
    logic [6:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          lat_fix;
    int          lat_et;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive a start at the current negedge, scramble inputs after the first edge,
  // and count edges until ready_o rises.
  task automatic do_op(input logic [6:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int lat);
    enable_i    = 1'b1;
    operator_i  = op;
    operand_a_i = a;
    operand_b_i = b;
    #1;
    check("ready_on_start", 32'(ready_o), 32'd0);
    lat = 0;
    do begin
      @(posedge core_clk);
      @(negedge core_clk);
      lat++;
      enable_i    = 1'b0;
      operator_i  = OP_DIVU;
      operand_a_i = ~a;
      operand_b_i = 32'h3;
    end while (!ready_o && lat < 100);
  endtask

  function automatic int exp_lat(input int fix, input int et);
`ifdef ALU_DIV_EARLY_TERM_EN
    return et;
`else
    return fix;
`endif
  endfunction

  initial begin
    int lat;

    vecs[0]  = '{OP_DIVU, 32'd100,        32'd7,          32'd14,         33, 8};
    vecs[1]  = '{OP_REMU, 32'd100,        32'd7,          32'd2,          33, 8};
    vecs[2]  = '{OP_DIV,  32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   33, 4};
    vecs[3]  = '{OP_REM,  32'hFFFFFFF9,   32'd2,          32'hFFFFFFFF,   33, 4};
    vecs[4]  = '{OP_DIVU, 32'd5,          32'd0,          32'hFFFFFFFF,   1,  1};
    vecs[5]  = '{OP_REMU, 32'd5,          32'd0,          32'd5,          1,  1};
    vecs[6]  = '{OP_DIV,  32'h80000000,   32'hFFFFFFFF,   32'h80000000,   1,  1};
    vecs[7]  = '{OP_REM,  32'h80000000,   32'hFFFFFFFF,   32'd0,          1,  1};
    vecs[8]  = '{OP_DIVU, 32'd5,          32'd2,          32'd2,          33, 4};
    vecs[9]  = '{OP_DIVU, 32'd0,          32'd3,          32'd0,          33, 1};
    vecs[10] = '{OP_DIV,  32'd100,        32'hFFFFFFF9,   32'hFFFFFFF2,   33, 8};
    vecs[11] = '{OP_DIVU, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   33, 33};
    vecs[12] = '{OP_REM,  32'hFFFFFF9C,   32'd7,          32'hFFFFFFFE,   33, 8};
    vecs[13] = '{OP_DIV,  32'h80000000,   32'd1,          32'h80000000,   33, 33};

    rst_n       = 1'b0;
    enable_i    = 1'b0;
    operator_i  = 7'd0;
    operand_a_i = 32'd0;
    operand_b_i = 32'd0;
    ex_ready_i  = 1'b1;
    repeat (2) @(negedge core_clk);
    check("rst_result", result_o, 32'd0);
    check("rst_ready", 32'(ready_o), 32'd1);
    check("rst_busy", 32'(busy_o), 32'd0);
    rst_n = 1'b1;
    @(negedge core_clk);

    foreach (vecs[i]) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, lat);
      check($sformatf("v%0d_lat", i), 32'(lat), 32'(exp_lat(vecs[i].lat_fix, vecs[i].lat_et)));
      check($sformatf("v%0d_res", i), result_o, vecs[i].res);
      check($sformatf("v%0d_busy", i), 32'(busy_o), 32'd0);
      @(posedge core_clk);
      @(negedge core_clk);
    end

    // Non-divide operator must never start the block.
    enable_i    = 1'b1;
    operator_i  = 7'b0000000;
    operand_a_i = 32'd100;
    operand_b_i = 32'd7;
    #1;
    check("nondiv_ready", 32'(ready_o), 32'd1);
    repeat (3) @(posedge core_clk);
    @(negedge core_clk);
    check("nondiv_busy", 32'(busy_o), 32'd0);
    check("nondiv_ready2", 32'(ready_o), 32'd1);
    enable_i = 1'b0;
    @(negedge core_clk);

    // Result held in DONE while EX stalls.
    ex_ready_i = 1'b0;
    do_op(OP_DIVU, 32'd100, 32'd7, lat);
    check("hold_lat", 32'(lat), 32'(exp_lat(33, 8)));
    for (int k = 0; k < 5; k++) begin
      check($sformatf("hold%0d_res", k), result_o, 32'd14);
      check($sformatf("hold%0d_ready", k), 32'(ready_o), 32'd1);
      @(posedge core_clk);
      @(negedge core_clk);
    end
    // Accept together with a new start: IDLE first, start taken a cycle later.
    ex_ready_i  = 1'b1;
    enable_i    = 1'b1;
    operator_i  = OP_DIVU;
    operand_a_i = 32'd9;
    operand_b_i = 32'd3;
    @(posedge core_clk);
    @(negedge core_clk);
    check("b2b_idle_ready", 32'(ready_o), 32'd0);
    check("b2b_idle_busy", 32'(busy_o), 32'd0);
    check("b2b_res_held", result_o, 32'd14);
    do_op(OP_DIVU, 32'd9, 32'd3, lat);
    check("b2b_lat", 32'(lat), 32'(exp_lat(33, 5)));
    check("b2b_res", result_o, 32'd3);
    @(posedge core_clk);
    @(negedge core_clk);

    // Asynchronous reset in the middle of an operation.
    enable_i    = 1'b1;
    operator_i  = OP_DIVU;
    operand_a_i = 32'hFFFFFFFF;
    operand_b_i = 32'd7;
    for (int k = 0; k < 10; k++) begin
      @(posedge core_clk);
      @(negedge core_clk);
      enable_i = 1'b0;
    end
    check("mid_busy", 32'(busy_o), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", 32'(ready_o), 32'd1);
    check("mid_rst_busy", 32'(busy_o), 32'd0);
    check("mid_rst_result", result_o, 32'd0);
    @(negedge core_clk);
    rst_n = 1'b1;
    @(negedge core_clk);
    check("post_rst_result", result_o, 32'd0);
    do_op(OP_DIVU, 32'd9, 32'd3, lat);
    check("post_rst_lat", 32'(lat), 32'(exp_lat(33, 5)));
    check("post_rst_res", result_o, 32'd3);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
